// File: rtl/serial_divisibility_word_feeder.sv
// Parallel-to-serial feeder for the divide-by-N checker FSMs: accepts a word,
// clears the checker, shifts the word MSB-first, then returns the checker's verdict.
module serial_divisibility_word_feeder #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         chk_rst,
  output logic         new_bit,
  input  logic         div_in,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_div,
  output logic [W-1:0] res_data
);

  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    SAMPLE,
    HOLD
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           res_div_q, res_div_d;
  logic [W-1:0]   res_data_q, res_data_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      res_div_q  <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      res_div_q  <= res_div_d;
      res_data_q <= res_data_d;
    end
  end

  // NOTE: every variable gets a hold-value default before the case so no
  // path through the block leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    res_div_d  = res_div_q;
    res_data_d = res_data_q;
    case (state_q)
      IDLE: begin
        // in_ready is 1 throughout IDLE, so in_valid alone completes the handshake.
        if (in_valid) begin
          state_d    = CLEAR;
          shreg_d    = in_data;
          res_data_d = in_data;
        end
      end
      CLEAR: begin
        state_d = SHIFT;
        cnt_d   = CW'(W - 1);
      end
      SHIFT: begin
        shreg_d = {shreg_q[W-2:0], 1'b0};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = SAMPLE;
      end
      SAMPLE: begin
        // The checker has absorbed the last bit at this point.
        state_d   = HOLD;
        res_div_d = div_in;
      end
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    chk_rst   = 1'b0;
    new_bit   = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      CLEAR:   chk_rst   = 1'b1;
      SHIFT:   new_bit   = shreg_q[W-1];
      HOLD:    res_valid = 1'b1;
      default: ;
    endcase
  end

  assign res_div  = res_div_q;
  assign res_data = res_data_q;

endmodule

// File: tb/tb_serial_divisibility_word_feeder.sv
// Bench for serial_divisibility_word_feeder: a behavioural divide-by-N checker
// drives div_in; directed timing scenarios plus a randomized scoreboard run.
module tb_serial_divisibility_word_feeder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         chk_rst;
  logic         new_bit;
  logic         div_in;
  logic         res_valid;
  logic         res_ready;
  logic         res_div;
  logic [W-1:0] res_data;

  int n_checks = 0;
  int n_errors = 0;
  int divisor  = 5;
  int chk_rem  = 0;
  int excl_viol = 0;

  serial_divisibility_word_feeder #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .chk_rst   (chk_rst),
    .new_bit   (new_bit),
    .div_in    (div_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_div   (res_div),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  // Behavioural checker: remainder of the bit stream seen so far modulo divisor.
  always @(posedge clk) begin
    if (chk_rst) chk_rem <= 0;
    else         chk_rem <= (chk_rem * 2 + int'(new_bit)) % divisor;
  end
  assign div_in = (chk_rem == 0);

  always @(negedge clk) begin
    if (in_ready && res_valid) excl_viol <= excl_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", in_ready, 1);
  endtask

  // Sends one word with res_ready=1 and checks the full per-cycle output trace.
  task automatic run_one(input logic [W-1:0] d, input logic exp_div);
    logic exp_nb;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    wait_in_ready();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '1;
    for (int k = 0; k <= W + 2; k++) begin
      exp_nb = (k >= 1 && k <= W) ? d[W-k] : 1'b0;
      check("trace", {in_ready, res_valid, chk_rst, new_bit},
            {1'b0, (k == W + 2), (k == 0), exp_nb});
      if (k < W + 2) @(negedge clk);
    end
    check("res_div", res_div, exp_div);
    check("res_data", res_data, d);
    @(negedge clk);
    check("back_idle", {in_ready, res_valid}, 2'b10);
  endtask

  logic [W-1:0] exp_q[$];

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outs", {in_ready, chk_rst, new_bit, res_valid, res_div},
          5'b10000);
    check("rst_data", res_data, 0);
    rst = 1'b0;

    // Directed, div-by-5 checker.
    divisor = 5;
    run_one(16'h0014, 1'b1);
    run_one(16'h0013, 1'b0);
    run_one(16'h0000, 1'b1);
    run_one(16'h8001, 1'b0);

    // Back-to-back with in_valid held high.
    begin
      int r1 = -1, r2 = -1, first_rdy = -1;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h0019;
      wait_in_ready();
      @(posedge clk);
      @(negedge clk);
      in_data = 16'h001A;
      for (int k = 0; k <= 45; k++) begin
        if (res_valid) begin
          if (r1 < 0) begin
            r1 = k;
            check("b2b_div1", res_div, 1);
            check("b2b_data1", res_data, 16'h0019);
          end else if (r2 < 0 && k != r1) begin
            r2 = k;
            check("b2b_div2", res_div, 0);
            check("b2b_data2", res_data, 16'h001A);
          end
        end
        if (in_ready && first_rdy < 0 && k > 0) first_rdy = k;
        if (first_rdy >= 0 && k == first_rdy + 1) in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b0;
      check("b2b_lat1", r1, 18);
      check("b2b_rdy", first_rdy, 19);
      check("b2b_lat2", r2, 38);
    end

    // Backpressure: hold the result for 5 cycles.
    begin
      int n = 0;
      res_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h0032;
      wait_in_ready();
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      while (!res_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("bp_rise", res_valid, 1);
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("bp_hold", {res_valid, res_div, res_data, in_ready},
              {1'b1, 1'b1, 16'h0032, 1'b0});
      end
      res_ready = 1'b1;
      @(negedge clk);
      check("bp_release", {in_ready, res_valid}, 2'b10);
    end

    // Reset in the 8th SHIFT cycle discards the word.
    begin
      int seen = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      wait_in_ready();
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst", {in_ready, res_valid, new_bit, chk_rst}, 4'b1000);
      check("mid_rst_data", {res_div, res_data}, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (res_valid) seen++;
        @(negedge clk);
      end
      check("no_result", seen, 0);
      run_one(16'h000F, 1'b1);
    end

    // Randomized: both checkers, random gaps and backpressure.
    for (int pass = 0; pass < 2; pass++) begin
      divisor = (pass == 0) ? 3 : 5;
      exp_q.delete();
      fork
        begin : producer
          for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = W'($urandom);
            wait_in_ready();
            exp_q.push_back(in_data);
            @(posedge clk);
          end
          @(negedge clk);
          in_valid = 1'b0;
        end
        begin : consumer
          int got = 0, cyc = 0;
          logic [W-1:0] e;
          while (got < 200 && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            res_ready = 1'($urandom_range(0, 1));
            if (res_valid && res_ready) begin
              if (exp_q.size() == 0) begin
                check("rnd_unexpected", 1, 0);
              end else begin
                e = exp_q.pop_front();
                check("rnd_data", res_data, e);
                check("rnd_div", res_div, ((int'(e) % divisor) == 0));
              end
              got++;
            end
          end
          check("rnd_count", got, 200);
          res_ready = 1'b1;
        end
      join
    end

    check("exclusive", excl_viol, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_divisibility_word_feeder.md
# serial_divisibility_word_feeder

Upstream feeder for the serial divisibility checkers (divide-by-3 / divide-by-5 FSMs). It accepts a parallel W-bit word over a valid/ready handshake and pulses the checker's synchronous reset. It then shifts the word MSB-first into the checker's `new_bit`, one bit per cycle. After the last bit it samples the checker's divisibility flag and returns it, with the original word, over a second valid/ready handshake.

## Interface
- `W`, default 16: word width; legal range 2..32.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  feeder can accept a word.
- `in_data`  in  W  word to test; unsigned.
- `chk_rst`  out  1  synchronous reset to the checker's `rst`.
- `new_bit`  out  1  serial bit to the checker's `new_bit`.
- `div_in`  in  1  checker flag (`div_by_3` or `div_by_5`).
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  downstream accepts the result.
- `res_div`  out  1  1 = word divisible by the checker's divisor.
- `res_data`  out  W  copy of the tested word.

## Operation
- States and their outputs:
  - IDLE: `in_ready`=1.
  - CLEAR: `chk_rst`=1, `new_bit`=0.
  - SHIFT: `new_bit` = `shreg[W-1]`.
  - SAMPLE: no outputs asserted.
  - HOLD: `res_valid`=1.
- All outputs are decoded from registered state. Every output not listed for a state is 0.
- IDLE -> CLEAR when `in_valid && in_ready` at a clock edge. That edge loads `shreg` and `res_data` with `in_data`.
- CLEAR -> SHIFT unconditionally. The bit counter `cnt` loads W-1 (width `$clog2(W)`).
- SHIFT: on each edge, `shreg` shifts left by 1 (zero fill) and `cnt` decrements.
  - SHIFT -> SAMPLE on the edge where `cnt`==0.
  - Exactly W bits are emitted, MSB first.
- SAMPLE -> HOLD unconditionally. That edge registers `res_div` <= `div_in`. At this point the checker has absorbed all W bits.
- HOLD -> IDLE on an edge with `res_ready`=1.
  - While `res_ready`=0, `res_valid`, `res_div` and `res_data` are held stable.
  - `in_ready` stays 0 while in HOLD.
- `in_data` is ignored outside the accept edge. `in_valid` deasserting mid-word has no effect.
- `div_in` is sampled only in SAMPLE and ignored in all other states.
- Reset (any time, including mid-SHIFT or in HOLD):
  - The FSM goes to IDLE immediately.
  - Output reset values: `in_ready`=1, `chk_rst`=0, `new_bit`=0, `res_valid`=0, `res_div`=0, `res_data`=0.
  - Internal reset values: `shreg`=0, `cnt`=0.
  - A word in flight is discarded and no result is produced for it.

## Timing
- Call the accept edge E0.
- CLEAR occupies the cycle E0..E1. The checker state is 0 after E1.
- Bit i (MSB = i=1) is driven during the cycle E(i)..E(i+1). The checker absorbs it at E(i+1).
- SAMPLE occupies E(W+1)..E(W+2). `res_div` is captured at E(W+2).
- `res_valid` rises after E(W+2): latency W+2 edges from accept.
- With `res_ready` held at 1, HOLD lasts one cycle. The next accept is possible at E(W+4). Throughput is one word per W+4 cycles.
- `in_ready` and `res_valid` are never 1 in the same cycle.

## Test plan
- W=16, paired with the div-by-5 checker, `res_ready`=1.
  - `in_data`=0x0014 (20) -> `res_valid` after E18, `res_div`=1, `res_data`=0x0014.
  - `in_data`=0x0013 (19) -> `res_div`=0.
  - `in_data`=0x0000 -> `res_div`=1.
- `in_data`=0x8001 -> `new_bit` sequence 1, 0×14, 1. `chk_rst`=1 only in the cycle before the first bit. `new_bit`=0 in all other states.
- Back-to-back: 0x0019 (25) then 0x001A (26), `in_valid` held high -> results 1 then 0. Second accept at E20, giving a 20-cycle spacing. The first result is unaffected by the second word.
- Backpressure: `res_ready`=0 for 5 cycles after `res_valid` rises -> `res_valid`, `res_div` and `res_data` are stable and `in_ready`=0. Raising `res_ready` returns the FSM to IDLE the next cycle.
- Assert `rst` during the 8th SHIFT cycle -> `in_ready`=1, `res_valid`=0, `new_bit`=0 at once. No result appears. The next word (0x000F, 15, div-by-5 checker) gives `res_div`=1.
- Random: 200 random words with random `in_valid`/`res_ready` gaps, against both the div-by-3 and div-by-5 checkers -> `res_div` == (`res_data` % 3 == 0) or (`res_data` % 5 == 0) respectively.
